// File: rtl/abs_diff_eval_sequencer_pkg.sv
// Shared types and width helpers for the absolute-difference evaluation sequencer.
package abs_diff_eval_pkg;

    // Sweep control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Operand-pair vector is {a,b}
    function automatic int vec_width(input int opw);
        return 2 * opw;
    endfunction

    // One extra bit so a full sweep where every vector fails still fits
    function automatic int cnt_width(input int opw);
        return 2 * opw + 1;
    endfunction

    localparam int DEF_OPW   = 2;
    localparam int DEF_VEC_W = 2 * DEF_OPW;
    localparam int DEF_CNT_W = 2 * DEF_OPW + 1;

endpackage

// File: rtl/abs_diff_eval_sequencer_if.sv
// Operand/result bus between the sequencer and the approximate core under test.
interface abs_diff_eval_sequencer_if #(
    parameter int OPW  = 2,
    parameter int OUTW = OPW + 1
);
    logic [OPW-1:0]  core_a;
    logic [OPW-1:0]  core_b;
    logic [OUTW-1:0] core_res;

    modport master (output core_a, output core_b, input core_res);
    modport slave  (input core_a, input core_b, output core_res);
endinterface

// File: rtl/abs_diff_eval_sequencer_exact.sv
// Exact |a-b| reference, zero-extended to the core result width.
module abs_diff_exact #(
    parameter int OPW  = 2,
    parameter int OUTW = OPW + 1
) (
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    output logic [OUTW-1:0] diff
);
    logic [OPW-1:0] mag;

    // Magnitude of the difference never needs more than OPW bits
    always_comb begin
        mag  = (a >= b) ? (a - b) : (b - a);
        diff = OUTW'(mag);
    end
endmodule

// File: rtl/abs_diff_eval_sequencer.sv
// Exhaustive sweep of an approximate |a-b| core with error statistics.
module abs_diff_eval_sequencer
    import abs_diff_eval_pkg::*;
#(
    parameter int OPW          = 2,
    parameter int OUTW         = OPW + 1,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [OUTW-1:0]             et,
    abs_diff_eval_sequencer_if.master   core,
    output logic                        busy,
    output logic                        done,
    output logic                        result_valid,
    output logic                        pass,
    output logic [OUTW-1:0]             max_err,
    output logic [cnt_width(OPW)-1:0]   err_count,
    output logic [vec_width(OPW)-1:0]   first_fail_vec
);
    localparam int VW = vec_width(OPW);
    localparam int CW = cnt_width(OPW);

    state_t          state;
    logic [VW-1:0]   vec;
    logic [OUTW-1:0] et_q;
    logic [OUTW-1:0] exact;
    logic [OUTW:0]   err_wide;
    logic [OUTW-1:0] err;
    logic [OUTW-1:0] max_next;
    logic [CW-1:0]   cnt_next;
    logic            viol;
    logic            terminal;
    logic            stop_now;

    // Clamp an OUTW+1-bit error magnitude into the OUTW-bit reporting range
    function automatic logic [OUTW-1:0] sat_err(input logic [OUTW:0] v);
        if (v[OUTW])
            return '1;
        return v[OUTW-1:0];
    endfunction

    abs_diff_exact #(.OPW(OPW), .OUTW(OUTW)) u_exact (
        .a    (core.core_a),
        .b    (core.core_b),
        .diff (exact)
    );

    // Operands follow the vector only while sweeping; idle bus is quiet
    always_comb begin
        core.core_a = '0;
        core.core_b = '0;
        if (state == S_RUN) begin
            core.core_a = vec[VW-1:OPW];
            core.core_b = vec[OPW-1:0];
        end
    end

    // Per-vector error evaluation and next statistics
    always_comb begin
        if (core.core_res >= exact)
            err_wide = {1'b0, core.core_res} - {1'b0, exact};
        else
            err_wide = {1'b0, exact} - {1'b0, core.core_res};
        err      = sat_err(err_wide);
        viol     = (err > et_q);
        max_next = (err > max_err) ? err : max_err;
        cnt_next = err_count + (viol ? CW'(1) : CW'(0));
        terminal = &vec;
        stop_now = terminal || ((STOP_ON_FAIL != 0) && viol);
    end

    // Sweep FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            vec            <= '0;
            et_q           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_valid   <= 1'b0;
            pass           <= 1'b0;
            max_err        <= '0;
            err_count      <= '0;
            first_fail_vec <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        busy           <= 1'b1;
                        vec            <= '0;
                        et_q           <= et;
                        result_valid   <= 1'b0;
                        pass           <= 1'b0;
                        max_err        <= '0;
                        err_count      <= '0;
                        first_fail_vec <= '1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        vec   <= '0;
                    end else begin
                        max_err   <= max_next;
                        err_count <= cnt_next;
                        // A zero count means nothing has been captured yet
                        if (viol && (err_count == '0))
                            first_fail_vec <= vec;
                        if (stop_now) begin
                            state        <= S_DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            result_valid <= 1'b1;
                            pass         <= (cnt_next == '0);
                            vec          <= '0;
                        end else begin
                            vec <= vec + VW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_abs_diff_eval_sequencer.sv
// Directed bench: two sequencers (free-running and stop-on-fail) over a stub core.
module tb_abs_diff_eval_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] et = 3'd1;
    int         mode = 0;   // 0: exact core, 1: tied to 0, 2: tied to 7

    logic       busy0, done0, rv0, pass0;
    logic [2:0] max0;
    logic [4:0] cnt0;
    logic [3:0] ffv0;
    logic       busy1, done1, rv1, pass1;
    logic [2:0] max1;
    logic [4:0] cnt1;
    logic [3:0] ffv1;

    int n_cmp = 0;
    int n_bad = 0;
    int k;
    logic seen;

    abs_diff_eval_sequencer_if #(.OPW(2), .OUTW(3)) bus0 ();
    abs_diff_eval_sequencer_if #(.OPW(2), .OUTW(3)) bus1 ();

    always #5 clk = ~clk;

    function automatic logic [2:0] stub(input int m, input logic [1:0] a, input logic [1:0] b);
        if (m == 1) return 3'd0;
        if (m == 2) return 3'd7;
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    always_comb bus0.core_res = stub(mode, bus0.core_a, bus0.core_b);
    always_comb bus1.core_res = stub(mode, bus1.core_a, bus1.core_b);

    abs_diff_eval_sequencer #(.OPW(2), .OUTW(3), .STOP_ON_FAIL(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort), .et(et), .core(bus0),
        .busy(busy0), .done(done0), .result_valid(rv0), .pass(pass0),
        .max_err(max0), .err_count(cnt0), .first_fail_vec(ffv0)
    );

    abs_diff_eval_sequencer #(.OPW(2), .OUTW(3), .STOP_ON_FAIL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .et(et), .core(bus1),
        .busy(busy1), .done(done1), .result_valid(rv1), .pass(pass1),
        .max_err(max1), .err_count(cnt1), .first_fail_vec(ffv1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on one DUT; returns just after the accepting edge
    task automatic go(input int which);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Edges from the accepting edge until done is seen, bounded
    task automatic wait_done(input int which, output int n);
        n = 0;
        while (n < 64) begin
            tick();
            n++;
            if ((which == 0) ? done0 : done1) break;
        end
    endtask

    task automatic chk_reset0(input string pfx);
        chk({pfx, "_busy"}, busy0, 0);
        chk({pfx, "_done"}, done0, 0);
        chk({pfx, "_rv"},   rv0, 0);
        chk({pfx, "_pass"}, pass0, 0);
        chk({pfx, "_max"},  max0, 0);
        chk({pfx, "_cnt"},  cnt0, 0);
        chk({pfx, "_ffv"},  ffv0, 4'hF);
        chk({pfx, "_ab"},   {bus0.core_a, bus0.core_b}, 0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk_reset0("rst0");
        chk("rst1_ffv", ffv1, 4'hF);

        // Exact core: clean full sweep
        mode = 0; et = 3'd1;
        go(0);
        chk("ex_busy", busy0, 1);
        wait_done(0, k);
        chk("ex_lat", k, 16);
        chk("ex_pass", pass0, 1);
        chk("ex_max", max0, 0);
        chk("ex_cnt", cnt0, 0);
        chk("ex_ffv", ffv0, 4'hF);
        chk("ex_rv", rv0, 1);
        chk("ex_busy_off", busy0, 0);
        tick();
        chk("ex_done_pulse", done0, 0);
        chk("ex_rv_hold", rv0, 1);

        // Core tied to 0
        mode = 1;
        go(0);
        chk("z_rv_clr", rv0, 0);
        wait_done(0, k);
        chk("z_lat", k, 16);
        chk("z_pass", pass0, 0);
        chk("z_max", max0, 3);
        chk("z_cnt", cnt0, 6);
        chk("z_ffv", ffv0, 4'b0010);

        // Same with stop-on-fail
        go(1);
        wait_done(1, k);
        chk("sf_lat", k, 3);
        chk("sf_cnt", cnt1, 1);
        chk("sf_ffv", ffv1, 4'b0010);
        chk("sf_pass", pass1, 0);
        chk("sf_max", max1, 2);

        // Core tied to 7: error saturated range, every vector fails
        mode = 2;
        go(0);
        wait_done(0, k);
        chk("s_lat", k, 16);
        chk("s_max", max0, 7);
        chk("s_cnt", cnt0, 16);
        chk("s_ffv", ffv0, 4'b0000);
        chk("s_pass", pass0, 0);

        // Threshold latched at start; later changes have no effect
        mode = 1; et = 3'd3;
        go(0);
        et = 3'd0;
        wait_done(0, k);
        chk("et_pass", pass0, 1);
        chk("et_cnt", cnt0, 0);
        chk("et_max", max0, 3);
        et = 3'd1;

        // Abort in RUN cycle 5
        mode = 0;
        go(0);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", busy0, 0);
        chk("ab_done", done0, 0);
        chk("ab_rv", rv0, 0);
        chk("ab_ab", {bus0.core_a, bus0.core_b}, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | done0;
        end
        chk("ab_no_done", seen, 0);

        // start and abort together in IDLE: start wins, then a clean sweep
        start0 = 1'b1; abort = 1'b1;
        tick();
        start0 = 1'b0; abort = 1'b0;
        chk("sa_busy", busy0, 1);
        wait_done(0, k);
        chk("sa_lat", k, 16);
        chk("sa_pass", pass0, 1);
        chk("sa_cnt", cnt0, 0);

        // start during RUN is ignored, then reset mid-sweep
        mode = 1;
        go(0);
        repeat (3) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("rs_vec", {bus0.core_a, bus0.core_b}, 4);
        chk("rs_busy", busy0, 1);
        chk("rs_cnt", cnt0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset0("mid");
        tick();
        chk("mid_stay_idle", busy0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
